// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: digit-scan controller for the 7-segment pattern decoder.
// Divides sys_clk into a CNT_MAX-cycle step tick, rotates an active-low
// one-hot digit select, and offers run/pause, direction, single-step and
// clear controls for board keys.
//
// Handshake: there is no back-pressure. end_cnt0 is a one-cycle strobe; the
// decoder samples Led_cnt / digit_idx / wrap in the same cycle end_cnt0 is
// high, and those values are already the new select at that point.
`timescale 1ns/1ps

module seg_scan_ctrl #(
    parameter int CNT_MAX = 50_000_000
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       run,
    input  logic       dir,
    input  logic       step,
    input  logic       clr,
    output logic       end_cnt0,
    output logic [7:0] Led_cnt,
    output logic [2:0] digit_idx,
    output logic       wrap,
    output logic       o_dbg_state
);

    // Prescaler width; CNT_MAX is at least 2 so this is at least 1.
    localparam int CW = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
    localparam logic [CW-1:0] LP_CNT_LAST = CW'(CNT_MAX - 1);
    localparam logic [7:0]    LP_SEL_HOME = 8'b1111_1110;

    typedef enum logic {
        S_PAUSE = 1'b0,
        S_RUN   = 1'b1
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt0;
    logic [7:0]    r_led;
    logic [2:0]    r_idx;
    logic          r_end_cnt0;
    logic          r_wrap;

    logic          w_tick;
    logic          w_adv;
    logic          w_legal;
    logic [7:0]    w_led_next;
    logic [2:0]    w_idx_next;
    logic          w_wrap_next;

    // True when the select has exactly one zero bit.
    function automatic logic one_zero(input logic [7:0] v);
        logic [3:0] zeros;
        zeros = 4'd0;
        for (int i = 0; i < 8; i++) begin
            zeros = zeros + {3'd0, ~v[i]};
        end
        return (zeros == 4'd1);
    endfunction

    // Run/pause state follows the run level every cycle.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= S_PAUSE;
        end else begin
            case (r_state)
                S_PAUSE: r_state <= run ? S_RUN : S_PAUSE;
                S_RUN:   r_state <= run ? S_RUN : S_PAUSE;
                default: r_state <= S_PAUSE;
            endcase
        end
    end

    // Tick on the last prescaler count; step only counts while paused.
    assign w_tick      = (r_state == S_RUN) && (r_cnt0 == LP_CNT_LAST);
    assign w_adv       = w_tick || (step && (r_state == S_PAUSE));
    assign w_legal     = one_zero(r_led);
    // dir=0 moves the zero to the next higher bit, dir=1 to the next lower.
    assign w_led_next  = dir ? {r_led[0], r_led[7:1]} : {r_led[6:0], r_led[7]};
    assign w_idx_next  = dir ? (r_idx - 3'd1) : (r_idx + 3'd1);
    assign w_wrap_next = dir ? (r_idx == 3'd0) : (r_idx == 3'd7);

    // Prescaler: counts only in S_RUN, holds while paused so a resume
    // continues the partial period; clear restarts it.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_cnt0 <= '0;
        end else if (clr) begin
            r_cnt0 <= '0;
        end else if (r_state == S_RUN) begin
            if (w_tick) begin
                r_cnt0 <= '0;
            end else begin
                r_cnt0 <= r_cnt0 + CW'(1);
            end
        end
    end

    // Digit select: clear wins, a corrupted select is repaired, else rotate.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_led <= LP_SEL_HOME;
            r_idx <= 3'd0;
        end else if (clr || !w_legal) begin
            r_led <= LP_SEL_HOME;
            r_idx <= 3'd0;
        end else if (w_adv) begin
            r_led <= w_led_next;
            r_idx <= w_idx_next;
        end
    end

    // Strobes to the decoder, registered alongside the select update.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_end_cnt0 <= 1'b0;
            r_wrap     <= 1'b0;
        end else begin
            r_end_cnt0 <= clr || (w_adv && w_legal);
            r_wrap     <= !clr && w_adv && w_legal && w_wrap_next;
        end
    end

    assign end_cnt0    = r_end_cnt0;
    assign Led_cnt     = r_led;
    assign digit_idx   = r_idx;
    assign wrap        = r_wrap;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: directed phases then random key activity, with a
// cycle-level reference model feeding an expected-pulse queue and a monitor
// that checks every end_cnt0 strobe and the select on every cycle.
`timescale 1ns/1ps

module tb_seg_scan_ctrl;

    localparam int CNT_MAX = 10;
    localparam int W       = 36;   // {cycle[31:0], idx[2:0], wrap}

    logic       sys_clk;
    logic       sys_rst_n;
    logic       run;
    logic       dir;
    logic       step;
    logic       clr;
    logic       end_cnt0;
    logic [7:0] Led_cnt;
    logic [2:0] digit_idx;
    logic       wrap;
    logic       o_dbg_state;

    logic [W-1:0] exp_q[$];

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Reference model state
    int m_idx   = 0;
    int m_phase = 0;
    bit m_run   = 0;
    bit m_pulse = 0;

    seg_scan_ctrl #(.CNT_MAX(CNT_MAX)) dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .run         (run),
        .dir         (dir),
        .step        (step),
        .clr         (clr),
        .end_cnt0    (end_cnt0),
        .Led_cnt     (Led_cnt),
        .digit_idx   (digit_idx),
        .wrap        (wrap),
        .o_dbg_state (o_dbg_state)
    );

    // ---------------- clock ----------------
    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] sel_of(input int idx);
        logic [7:0] one;
        one = 8'd1;
        return ~(one << idx);
    endfunction

    // ---------------- reference model ----------------
    // Select position is an integer 0..7; the period is a phase counter.
    always @(posedge sys_clk) begin
        bit tick;
        bit adv;
        bit w;
        cyc++;
        m_pulse = 0;
        if (!sys_rst_n) begin
            m_idx = 0; m_phase = 0; m_run = 0;
        end else begin
            tick = m_run && (m_phase == CNT_MAX - 1);
            adv  = tick || (!m_run && step);
            if (clr) begin
                m_idx = 0;
                m_phase = 0;
                exp_q.push_back({32'(cyc), 3'd0, 1'b0});
                m_pulse = 1;
            end else begin
                if (adv) begin
                    w = dir ? (m_idx == 0) : (m_idx == 7);
                    m_idx = dir ? (m_idx + 7) % 8 : (m_idx + 1) % 8;
                    exp_q.push_back({32'(cyc), 3'(m_idx), w});
                    m_pulse = 1;
                end
                if (m_run) m_phase = (m_phase + 1) % CNT_MAX;
            end
            m_run = run;
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge sys_clk) begin
        logic [W-1:0] e;
        if (!sys_rst_n) begin
            chk("rst_end_cnt0", 32'(end_cnt0), 32'd0);
            chk("rst_wrap", 32'(wrap), 32'd0);
            chk("rst_led", 32'(Led_cnt), 32'hFE);
            chk("rst_idx", 32'(digit_idx), 32'd0);
            chk("rst_state", 32'(o_dbg_state), 32'd0);
            // A strobe due this cycle was cancelled by the reset.
            while (exp_q.size() > 0 && exp_q[0][35:4] == 32'(cyc)) void'(exp_q.pop_front());
        end else begin
            if (end_cnt0) begin
                if (exp_q.size() == 0 || exp_q[0][35:4] != 32'(cyc)) begin
                    n_checks++; n_errors++;
                    $display("FAIL unexpected_pulse: end_cnt0=1 expected 0 (cycle %0d)", cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("pulse_led", 32'(Led_cnt), 32'(sel_of(int'(e[3:1]))));
                    chk("pulse_idx", 32'(digit_idx), 32'(e[3:1]));
                    chk("pulse_wrap", 32'(wrap), 32'(e[0]));
                end
            end else begin
                if (exp_q.size() > 0 && exp_q[0][35:4] <= 32'(cyc)) begin
                    void'(exp_q.pop_front());
                    n_checks++; n_errors++;
                    $display("FAIL missing_pulse: end_cnt0=0 expected 1 (cycle %0d)", cyc);
                end
                chk("idle_wrap", 32'(wrap), 32'd0);
            end
            chk("sel_led", 32'(Led_cnt), 32'(sel_of(m_idx)));
            chk("sel_idx", 32'(digit_idx), 32'(m_idx));
            chk("state", 32'(o_dbg_state), 32'(m_run));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic next_cycle(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic pulse_step();
        step = 1'b1; next_cycle(1); step = 1'b0;
    endtask

    task automatic pulse_clr();
        clr = 1'b1; next_cycle(1); clr = 1'b0;
    endtask

    task automatic timeout(input string nm);
        n_checks++; n_errors++;
        $display("FAIL %s: wait expired, condition never reached (cycle %0d)", nm, cyc);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int budget;
        sys_rst_n = 1'b0;
        run = 1'b0; dir = 1'b0; step = 1'b0; clr = 1'b0;
        next_cycle(3);
        sys_rst_n = 1'b1;
        next_cycle(2);

        // Free run upward through a full rotation and past the wrap.
        run = 1'b1; dir = 1'b0;
        next_cycle(9 * CNT_MAX + 5);

        // Reverse direction.
        dir = 1'b1;
        next_cycle(3 * CNT_MAX);

        // Paused single steps, upward.
        run = 1'b0; dir = 1'b0;
        next_cycle(5);
        repeat (3) begin
            pulse_step();
            next_cycle(3);
        end

        // Step while running is ignored.
        run = 1'b1;
        next_cycle(4);
        pulse_step();
        next_cycle(2 * CNT_MAX);

        // Pause mid-period for 50 cycles, then resume the partial period.
        budget = 0;
        while (!(m_run && m_phase == 6) && budget < 4 * CNT_MAX) begin next_cycle(1); budget++; end
        if (budget >= 4 * CNT_MAX) timeout("wait_phase6");
        run = 1'b0;
        next_cycle(50);
        run = 1'b1;
        next_cycle(2 * CNT_MAX);

        // Clear landing on a tick edge while the select sits on digit 4.
        budget = 0;
        while (!(m_run && m_phase == CNT_MAX - 1 && m_idx == 4) && budget < 20 * CNT_MAX) begin
            next_cycle(1); budget++;
        end
        if (budget >= 20 * CNT_MAX) timeout("wait_tick_idx4");
        pulse_clr();
        next_cycle(2 * CNT_MAX + 3);

        // Clear followed immediately by a step while paused.
        run = 1'b0;
        next_cycle(3);
        clr = 1'b1; next_cycle(1);
        clr = 1'b0; step = 1'b1; next_cycle(1);
        step = 1'b0;
        next_cycle(5);

        // Random key activity.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 31) == 0) run = ~run;
            if ($urandom_range(0, 47) == 0) dir = ~dir;
            step = !step && ($urandom_range(0, 7) == 0);
            clr  = ($urandom_range(0, 59) == 0);
            next_cycle(1);
        end
        step = 1'b0; clr = 1'b0;

        // Async reset right after an advance onto digit 6 (select BF).
        run = 1'b1; dir = 1'b0;
        budget = 0;
        while (!(m_pulse && m_idx == 6) && budget < 30 * CNT_MAX) begin next_cycle(1); budget++; end
        if (budget >= 30 * CNT_MAX) timeout("wait_idx6");
        chk("pre_rst_pulse", 32'(end_cnt0), 32'd1);
        #2;
        sys_rst_n = 1'b0;
        #1;
        chk("async_end_cnt0", 32'(end_cnt0), 32'd0);
        chk("async_led", 32'(Led_cnt), 32'hFE);
        chk("async_idx", 32'(digit_idx), 32'd0);
        chk("async_wrap", 32'(wrap), 32'd0);
        run = 1'b0;
        next_cycle(3);
        sys_rst_n = 1'b1;
        next_cycle(30);
        run = 1'b1;
        next_cycle(CNT_MAX + 5);
        run = 1'b0;
        next_cycle(3);

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
